// File: rtl/traffic_light_param.sv
// Parametrised highway/farm-road intersection controller with built-in tick divider.
// Optional feature macro: PED_EN (pedestrian request input and walk lamp).
module traffic_light_param #(
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned GREEN_MIN  = 5,
  parameter int unsigned YELLOW_T   = 3,
  parameter int unsigned FARM_GREEN = 10,
  parameter int unsigned ALL_RED_T  = 1,
  parameter int unsigned CNT_W      = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       C,
  input  logic       ped_req,
  output logic [2:0] light_highway,
  output logic [2:0] light_farm,
  output logic       walk,
  output logic [2:0] state_o,
  output logic       tick_o
);

  typedef enum logic [2:0] {
    HGRE_FRED = 3'd0,
    HYEL_FRED = 3'd1,
    ARED1     = 3'd2,
    HRED_FGRE = 3'd3,
    HRED_FYEL = 3'd4,
    ARED2     = 3'd5
  } state_t;

  localparam int unsigned AR_LAST_I = (ALL_RED_T == 0) ? 0 : ALL_RED_T - 1;
  localparam bit          HAS_AR    = (ALL_RED_T != 0);

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] FARM_LAST  = CNT_W'(FARM_GREEN - 1);
  localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(AR_LAST_I);
  localparam logic [CNT_W-1:0] PHASE_MAX  = {CNT_W{1'b1}};

  localparam logic [5:0] LAMPS_RESET = 6'b001_100;

  logic [CNT_W-1:0] div_r;
  logic [CNT_W-1:0] phase_r;
  state_t           state_r;
  state_t           state_s;
  logic             req_r;
  logic             req_set_s;
  logic             tick_s;
  logic             enter_farm_s;
  logic [5:0]       lamps_r;
  logic             walk_r;

  // Lamp code {highway, farm} for a given state.
  function automatic logic [5:0] lamp_decode(input state_t s);
    logic [5:0] l;
    case (s)
      HGRE_FRED: l = 6'b001_100;
      HYEL_FRED: l = 6'b010_100;
      ARED1:     l = 6'b100_100;
      HRED_FGRE: l = 6'b100_001;
      HRED_FYEL: l = 6'b100_010;
      ARED2:     l = 6'b100_100;
      default:   l = 6'b001_100;
    endcase
    return l;
  endfunction

`ifdef PED_EN
  assign req_set_s = C | ped_req;
`else
  logic unused_ped_s;
  assign unused_ped_s = ped_req;
  assign req_set_s    = C;
`endif

  assign tick_s        = (div_r == DIV_LAST);
  assign enter_farm_s  = (state_s == HRED_FGRE) && (state_r != HRED_FGRE);

  assign tick_o        = tick_s;
  assign state_o       = state_r;
  assign light_highway = lamps_r[5:3];
  assign light_farm    = lamps_r[2:0];
  assign walk          = walk_r;

  // Free-running tick divider.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_r <= '0;
    end else if (tick_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + ONE;
    end
  end

  // Next-state logic; transitions only in tick cycles, illegal codes recover to highway green.
  always_comb begin
    state_s = state_r;
    case (state_r)
      HGRE_FRED: begin
        if (tick_s && req_r && (phase_r >= GREEN_LAST)) state_s = HYEL_FRED;
        else                                            state_s = state_r;
      end
      HYEL_FRED: begin
        if (tick_s && (phase_r == YEL_LAST)) state_s = HAS_AR ? ARED1 : HRED_FGRE;
        else                                 state_s = state_r;
      end
      ARED1: begin
        if (tick_s && (phase_r == AR_LAST)) state_s = HRED_FGRE;
        else                                state_s = state_r;
      end
      HRED_FGRE: begin
        if (tick_s && (phase_r == FARM_LAST)) state_s = HRED_FYEL;
        else                                  state_s = state_r;
      end
      HRED_FYEL: begin
        if (tick_s && (phase_r == YEL_LAST)) state_s = HAS_AR ? ARED2 : HGRE_FRED;
        else                                 state_s = state_r;
      end
      ARED2: begin
        if (tick_s && (phase_r == AR_LAST)) state_s = HGRE_FRED;
        else                                state_s = state_r;
      end
      default: state_s = HGRE_FRED;
    endcase
  end

  // State register with lamps and walk registered alongside so they change together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= HGRE_FRED;
      lamps_r <= LAMPS_RESET;
      walk_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      lamps_r <= lamp_decode(state_s);
`ifdef PED_EN
      walk_r  <= (state_s == HRED_FGRE);
`else
      walk_r  <= 1'b0;
`endif
    end
  end

  // Phase counter: restarts on every state change, counts ticks, saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_r <= '0;
    end else if (state_s != state_r) begin
      phase_r <= '0;
    end else if (tick_s && (phase_r != PHASE_MAX)) begin
      phase_r <= phase_r + ONE;
    end else begin
      phase_r <= phase_r;
    end
  end

  // Request latch; a new request wins over the clear on entry to farm green.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_r <= 1'b0;
    end else if (req_set_s) begin
      req_r <= 1'b1;
    end else if (enter_farm_s) begin
      req_r <= 1'b0;
    end else begin
      req_r <= req_r;
    end
  end

endmodule
